// File: rtl/struct_array_pkg.sv
// Shared definitions for the struct-array packer and unpacker pair.
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_B_W / DEFAULT_C_W / DEFAULT_ELEM_W
//              - default array geometry shared by both sides of the link
//   elem_t     - one array slot, MSB to LSB {a, b, c}
//   state_t    - packer FSM states {FILL, HOLD}
package struct_array_pkg;

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_B_W    = 4;
    localparam int DEFAULT_C_W    = 2;
    localparam int DEFAULT_ELEM_W = 1 + DEFAULT_B_W + DEFAULT_C_W;

    // Field order here is the wire order of a slot. The unpacker relies on
    // it, so a reorder changes the link format.
    typedef struct packed {
        logic                   a;
        logic [DEFAULT_B_W-1:0] b;
        logic [DEFAULT_C_W-1:0] c;
    } elem_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/struct_elem_pack.sv
// Combinational slot builder: concatenates the separate element fields into
// one slot word in the shared {a, b, c} layout (a at the MSB, c at the LSBs).
// For the default widths the result is bit-identical to elem_t.
//
// Ports:
//   a     in   1               field a
//   b     in   B_W             field b
//   c     in   C_W             field c
//   elem  out  1+B_W+C_W       packed slot word
module struct_elem_pack #(
    parameter int B_W = 4,
    parameter int C_W = 2
) (
    input  logic             a,
    input  logic [B_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    output logic [B_W+C_W:0] elem
);

    assign elem = {a, b, c};

endmodule

// File: rtl/struct_array_packer.sv
// Transmit-side struct-array packer. Collects one element per input handshake
// into successive slots of a packed array (slot 0 at the LSBs) and offers the
// whole array on the output when the array is full or the frame is ended
// early with in_last.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid && ready are both high. valid, once raised by the DUT, is held with
// stable data until the transfer. in_ready and out_valid are decoded from the
// FSM state only, so there is no combinational path from in_valid/out_ready.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous reset, active-high
//   in_valid   in   1              element offered
//   in_ready   out  1              high while filling
//   in_a       in   1              field a
//   in_b       in   B_W            field b
//   in_c       in   C_W            field c
//   in_last    in   1              this element ends the frame early
//   out_valid  out  1              packed frame available
//   out_ready  in   1              consumer takes the frame
//   out_data   out  DEPTH*ELEM_W   packed array, slot i at [i*ELEM_W +: ELEM_W]
//   out_count  out  CNT_W          slots written in the current frame
module struct_array_packer
    import struct_array_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int B_W   = DEFAULT_B_W,
    parameter int C_W   = DEFAULT_C_W,
    localparam int ELEM_W = 1 + B_W + C_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_a,
    input  logic [B_W-1:0]          in_b,
    input  logic [C_W-1:0]          in_c,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEPTH*ELEM_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wr_idx;
    logic [ELEM_W-1:0]  elem;
    logic               accept;
    logic               frame_end;
    logic               handoff;

    struct_elem_pack #(
        .B_W (B_W),
        .C_W (C_W)
    ) u_elem_pack (
        .a    (in_a),
        .b    (in_b),
        .c    (in_c),
        .elem (elem)
    );

    // Next state and handshake decode. The output handshake only exists in
    // HOLD and an accept only in FILL, so the two never share a cycle; the
    // cycle after a handoff is the one-cycle bubble back in FILL.
    always_comb begin
        state_next = state;
        in_ready   = (state == FILL);
        out_valid  = (state == HOLD);
        accept     = (state == FILL) && in_valid;
        handoff    = (state == HOLD) && out_ready;
        // in_last on the final slot lands here too, same as a full frame.
        frame_end  = accept && ((wr_idx == LAST_IDX) || in_last);
        case (state)
            FILL:    if (frame_end) state_next = HOLD;
            HOLD:    if (out_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Datapath. Clearing out_data on handoff is what makes unwritten slots of
    // a short frame read as zero, with no residue from the previous frame.
    // wr_idx cannot pass LAST_IDX because the frame closes on that accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx    <= '0;
            out_count <= '0;
            out_data  <= '0;
        end else if (accept) begin
            out_data[int'(wr_idx)*ELEM_W +: ELEM_W] <= elem;
            wr_idx    <= wr_idx + CNT_W'(1);
            out_count <= out_count + CNT_W'(1);
        end else if (handoff) begin
            wr_idx    <= '0;
            out_count <= '0;
            out_data  <= '0;
        end
    end

endmodule

// File: tb/tb_struct_array_packer.sv
// Bench for struct_array_packer: directed frames from the datasheet plus
// randomized frames, checked by a scoreboard fed from an element-list model.
module tb_struct_array_packer;
    import struct_array_pkg::*;

    localparam int DEPTH  = 8;
    localparam int B_W    = 4;
    localparam int C_W    = 2;
    localparam int ELEM_W = 1 + B_W + C_W;
    localparam int DW     = DEPTH * ELEM_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] T1_LIT =
        56'b01111011011011101111100111110111001010001011100110101000;
    localparam logic [DW-1:0] T3_LIT = {35'd0, 21'b010001011100110101000};
    localparam logic [DW-1:0] T4_LIT = 56'h5B;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_a;
    logic [B_W-1:0]    in_b;
    logic [C_W-1:0]    in_c;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CNT_W-1:0]  out_count;

    always #5 clk = ~clk;

    struct_array_packer #(.DEPTH(DEPTH), .B_W(B_W), .C_W(C_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;

    logic [DW-1:0]     exp_q[$];
    logic [CNT_W-1:0]  cnt_q[$];
    logic [ELEM_W-1:0] frame_elems[$];

    int            cons_delay = 0;
    logic          lit_en = 1'b0;
    logic [DW-1:0] lit_val = '0;

    logic [ELEM_W-1:0] t1 [DEPTH] = '{7'b0101000, 7'b1110011, 7'b0100010,
                                      7'b0111001, 7'b0011111, 7'b1011111,
                                      7'b1011011, 7'b0111101};

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is the list of accepted elements; slot i holds
    // element i, everything above the list is zero.
    task automatic close_frame();
        logic [DW-1:0] v;
        v = '0;
        foreach (frame_elems[i]) v = v | (DW'(frame_elems[i]) << (i * ELEM_W));
        if (lit_en) begin
            v      = lit_val;
            lit_en = 1'b0;
        end
        exp_q.push_back(v);
        cnt_q.push_back(CNT_W'(frame_elems.size()));
        frame_elems.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Main-flow time is kept at 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [ELEM_W-1:0] e, input logic last);
        logic rdy;
        rdy      = 1'b0;
        in_valid = 1'b1;
        in_a     = e[ELEM_W-1];
        in_b     = e[B_W+C_W-1:C_W];
        in_c     = e[C_W-1:0];
        in_last  = last;
        for (int g = 0; g < 200; g++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected accept within 200 cycles");
        end else begin
            frame_elems.push_back(e);
            if (frame_elems.size() == DEPTH || last) close_frame();
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            tick(1);
            g++;
        end
        check("drain_done", 64'(g < 500), 64'd1);
    endtask

    // ---------------- consumer: out_ready after cons_delay cycles ----------------
    initial begin
        int wc;
        wc = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !out_valid) begin
                out_ready = 1'b0;
                wc = 0;
            end else if (wc >= cons_delay) begin
                out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                wc++;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic          in_frame;
        logic          prev_hs;
        logic [DW-1:0] cur_d;
        logic [CNT_W-1:0] cur_c;
        in_frame = 1'b0;
        prev_hs  = 1'b0;
        cur_d    = '0;
        cur_c    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                prev_hs  = 1'b0;
            end else begin
                if (prev_hs) begin
                    check("post_hs_out_valid", 64'(out_valid), 64'd0);
                    check("post_hs_in_ready", 64'(in_ready), 64'd1);
                    check("post_hs_out_data", 64'(out_data), 64'd0);
                    check("post_hs_out_count", 64'(out_count), 64'd0);
                end
                if (out_valid) begin
                    if (!in_frame) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_frame: got data 0x%0h expected no frame", out_data);
                            cur_d = out_data;
                            cur_c = out_count;
                        end else begin
                            cur_d = exp_q.pop_front();
                            cur_c = cnt_q.pop_front();
                        end
                        in_frame = 1'b1;
                    end
                    check("frame_data", 64'(out_data), 64'(cur_d));
                    check("frame_count", 64'(out_count), 64'(cur_c));
                    check("frame_in_ready_low", 64'(in_ready), 64'd0);
                end
                prev_hs = out_valid && out_ready;
                if (prev_hs) in_frame = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = 1'b0;
        in_b     = '0;
        in_c     = '0;
        in_last  = 1'b0;
        tick(2);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        tick(1);

        // Full frame, then hold with out_ready low while in_valid is driven.
        cons_delay = 5;
        lit_en  = 1'b1;
        lit_val = T1_LIT;
        for (int i = 0; i < DEPTH; i++) send(t1[i], 1'b0);
        check("t1_valid_latency", 64'(out_valid), 64'd1);
        check("t1_out_count", 64'(out_count), 64'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 1'($urandom);
            in_b = B_W'($urandom);
            in_c = C_W'($urandom);
            check("t2_in_ready_low", 64'(in_ready), 64'd0);
            check("t2_data_stable", 64'(out_data), 64'(T1_LIT));
            tick(1);
        end
        in_valid = 1'b0;
        begin
            int g;
            g = 0;
            while (out_valid && g < 20) begin
                tick(1);
                g++;
            end
        end
        check("t2_out_valid_low", 64'(out_valid), 64'd0);
        check("t2_in_ready_high", 64'(in_ready), 64'd1);

        // Early-ended frame followed back-to-back by a one-element frame.
        cons_delay = 0;
        lit_en  = 1'b1;
        lit_val = T3_LIT;
        send(t1[0], 1'b0);
        send(t1[1], 1'b0);
        send(t1[2], 1'b1);
        lit_en  = 1'b1;
        lit_val = T4_LIT;
        send(7'b1011011, 1'b1);
        drain();

        // Asynchronous reset mid-cycle with a partial frame.
        for (int i = 0; i < 4; i++) send(ELEM_W'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_data", 64'(out_data), 64'd0);
        check("t5_out_count", 64'(out_count), 64'd0);
        frame_elems.delete();
        tick(1);
        rst = 1'b0;
        check("t5_in_ready", 64'(in_ready), 64'd1);

        // Test 1 again with idle gaps and a random consumer delay.
        cons_delay = $urandom_range(0, 6);
        lit_en  = 1'b1;
        lit_val = T1_LIT;
        for (int i = 0; i < DEPTH; i++) begin
            tick($urandom_range(0, 3));
            send(t1[i], 1'b0);
        end
        drain();

        // Random frames of random length against the model.
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            cons_delay = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                logic last;
                if (i == n - 1) last = (n < DEPTH) ? 1'b1 : 1'($urandom);
                else            last = 1'b0;
                tick($urandom_range(0, 2));
                send(ELEM_W'($urandom), last);
            end
        end
        drain();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
